// File: rtl/mse_result_framer_pkg.sv
// framer_pkg: shared constants, types and helpers for mse_result_framer.
//   SOF_BYTE       default start-of-frame marker
//   framer_state_t framer FSM encoding
//   frame_len()    bytes per frame: SOF + channel index + data bytes + CHK
package framer_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [1:0] {IDLE, SEND, GAP} framer_state_t;

    function automatic int frame_len(input int data_w);
        return data_w / 8 + 3;
    endfunction

endpackage

// File: rtl/mse_result_framer_byte_pacer.sv
// byte_pacer: paces the framer's byte strobes.
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   start  in   pulse in the cycle a byte is strobed
//   done   out  single-cycle pulse in the last cycle before the next byte may be strobed
// The strobe cycle itself counts towards the gap, so after start the pacer runs
// BYTE_GAP-1 cycles; the counter holds the cycles remaining until the next strobe.
// BYTE_GAP must be at least 2.
module byte_pacer #(
    parameter int BYTE_GAP = 8700
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int CNT_W = $clog2(BYTE_GAP);

    logic [CNT_W-1:0] gap_cnt_q;
    logic             run_q;

    assign done = run_q && (gap_cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt_q <= '0;
            run_q     <= 1'b0;
        end else if (start) begin
            gap_cnt_q <= CNT_W'(BYTE_GAP - 1);
            run_q     <= 1'b1;
        end else if (run_q) begin
            gap_cnt_q <= gap_cnt_q - CNT_W'(1);
            if (done) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mse_result_framer.sv
// mse_result_framer: packs per-channel MSE results into byte frames for a
// ready-less UART transmitter.
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   mse_data     in   per-channel result, sampled on its mse_valid bit
//   mse_valid    in   per-channel single-cycle result strobe
//   ovr_clr      in   clears all overrun flags (a same-cycle set wins)
//   com_txvalid  out  single-cycle byte strobe
//   com_txdata   out  frame byte, zero outside strobes
//   busy         out  frame in progress
//   overrun      out  sticky per-channel "result dropped" flags
// Frame: SOF, channel index, data bytes MSB first, CHK (XOR of index and data).
module mse_result_framer
    import framer_pkg::*;
#(
    parameter int         NUM_SYS  = 2,
    parameter int         DATA_W   = 64,
    parameter int         BYTE_GAP = 8700,
    parameter logic [7:0] SOF      = SOF_BYTE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SYS-1:0][DATA_W-1:0] mse_data,
    input  logic [NUM_SYS-1:0]             mse_valid,
    input  logic                           ovr_clr,
    output logic                           com_txvalid,
    output logic [7:0]                     com_txdata,
    output logic                           busy,
    output logic [NUM_SYS-1:0]             overrun
);

    localparam int LEN   = frame_len(DATA_W);
    localparam int IDX_W = $clog2(LEN);
    localparam int CH_W  = (NUM_SYS > 1) ? $clog2(NUM_SYS) : 1;

    logic [NUM_SYS-1:0][DATA_W-1:0] hold_q;
    logic [NUM_SYS-1:0]             pend_q;
    logic [NUM_SYS-1:0]             ovr_q;
    framer_state_t                  state_q;
    logic [DATA_W-1:0]              shift_q;
    logic [7:0]                     chk_q;
    logic [IDX_W-1:0]               idx_q;
    logic [CH_W-1:0]                chan_q;

    logic [CH_W-1:0] sel;
    logic            load;
    logic            gap_done;
    logic [7:0]      tx_byte;

    // Lowest pending channel wins; only consulted in IDLE so a frame is never preempted.
    always_comb begin
        sel = '0;
        for (int i = NUM_SYS - 1; i >= 0; i--)
            if (pend_q[i]) sel = CH_W'(i);
    end

    assign load = (state_q == IDLE) && (|pend_q);

    always_comb begin
        tx_byte = shift_q[DATA_W-1 -: 8];
        if (idx_q == '0)                     tx_byte = SOF;
        else if (idx_q == IDX_W'(1))         tx_byte = 8'(chan_q);
        else if (idx_q == IDX_W'(LEN - 1))   tx_byte = chk_q;
    end

    assign com_txvalid = (state_q == SEND);
    assign com_txdata  = com_txvalid ? tx_byte : 8'h00;
    assign busy        = (state_q != IDLE);
    assign overrun     = ovr_q;

    // Capture side. A new result arriving in the same cycle the FSM takes this
    // channel's hold register refills it rather than counting as an overrun.
    // The clear is written first so a coincident set overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            if (ovr_clr) ovr_q <= '0;
            for (int i = 0; i < NUM_SYS; i++) begin
                if (mse_valid[i]) begin
                    if (!pend_q[i] || (load && sel == CH_W'(i))) begin
                        hold_q[i] <= mse_data[i];
                        pend_q[i] <= 1'b1;
                    end else begin
                        ovr_q[i]  <= 1'b1;
                    end
                end else if (load && sel == CH_W'(i)) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    byte_pacer #(.BYTE_GAP(BYTE_GAP)) u_pacer (
        .clk   (clk),
        .rst   (rst),
        .start (state_q == SEND),
        .done  (gap_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            chan_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (load) begin
                    shift_q <= hold_q[sel];
                    chan_q  <= sel;
                    idx_q   <= '0;
                    chk_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    // CHK covers the index byte and every data byte.
                    if (idx_q >= IDX_W'(1) && idx_q <= IDX_W'(LEN - 2))
                        chk_q <= chk_q ^ tx_byte;
                    if (idx_q >= IDX_W'(2) && idx_q <= IDX_W'(LEN - 2))
                        shift_q <= shift_q << 8;
                    state_q <= GAP;
                end
                GAP: if (gap_done) begin
                    if (idx_q == IDX_W'(LEN - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= SEND;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
